// File: rtl/reg_flagbank.sv
// rtl/reg_flagbank.sv - parametrised flag bank with per-bit modifiers and save/restore stack
module reg_flagbank #(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               nreset,
  input  logic [NFLAGS-1:0]                  clr,
  input  logic [NFLAGS-1:0]                  cpl,
  input  logic                               we,
  input  logic [NFLAGS-1:0]                  wdata,
  input  logic                               alu_load,
  input  logic [NFLAGS-1:0]                  alu_mask,
  input  logic [NFLAGS-1:0]                  alu_flags,
  input  logic                               shift_en,
  input  logic                               shift_in,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               err_clr,
  output logic [NFLAGS-1:0]                  flags,
  output logic [NFLAGS-1:0]                  flags_fast,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic                               stack_err
);

  localparam int DW    = $clog2(STACK_DEPTH+1);
  // Storage sized to the full index range so depth-width indices never go out of bounds.
  localparam int SLOTS = 1 << DW;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;
  logic [NFLAGS-1:0] stack_q [SLOTS];

  logic [DW-1:0]     top_idx;
  logic              empty, full;
  logic              pop_src, push_only, pop_only, xchg, err_set;
  logic              wr_en;
  logic [DW-1:0]     wr_idx;
  logic [NFLAGS-1:0] top_val;

  // Stack occupancy decode and the effective push/pop/exchange actions.
  always_comb begin
    empty     = (depth_q == '0);
    full      = (depth_q == DW'(STACK_DEPTH));
    top_idx   = depth_q - DW'(1);
    top_val   = stack_q[top_idx];
    pop_src   = pop & ~empty;
    push_only = push & ~pop & ~full;
    pop_only  = pop & ~push & ~empty;
    xchg      = push & pop & ~empty;
    err_set   = (push & ~pop & full) | (pop & empty);
    wr_en     = push_only | xchg;
    wr_idx    = push_only ? depth_q : top_idx;
  end

  // Per-bit next flag value: priority-selected base, then clear/complement modifier.
  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < NFLAGS; i++) begin
      logic base;
      base = flags_q[i];
      if (pop_src)                      base = top_val[i];
      else if (we)                      base = wdata[i];
      else if (alu_load && alu_mask[i]) base = alu_flags[i];
      else if (i == 0 && shift_en)      base = shift_in;
      if (clr[i])      flags_d[i] = 1'b0;
      else if (cpl[i]) flags_d[i] = ~base;
      else             flags_d[i] = base;
    end
  end

  // Depth saturates at both ends; overflow/underflow raises the sticky error.
  always_comb begin
    depth_d = depth_q;
    if (push_only)     depth_d = depth_q + DW'(1);
    else if (pop_only) depth_d = depth_q - DW'(1);
    err_d = err_q;
    if (err_set)       err_d = 1'b1;
    else if (err_clr)  err_d = 1'b0;
  end

  // Architectural state with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (nreset) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; writes capture the pre-update flags.
  always_ff @(posedge clk) begin
    if (!nreset && wr_en) stack_q[wr_idx] <= flags_q;
  end

  assign flags       = flags_q;
  assign flags_fast  = nreset ? '0 : flags_d;
  assign stack_depth = depth_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_err   = err_q;

endmodule
